// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DEFAULT_WIDTH = 32;
  localparam int PIPE_DEFAULT_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage with a two-entry skid buffer and registered in_ready.
// Optional statistics counters are built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int CNT_W = PIPE_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_e      state;
  pipe_state_e      state_nx;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_d_nx;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_d_nx;
  logic             main_v;
  logic             in_fire;
  logic             out_fire;

  assign main_v    = (state != PS_EMPTY);
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready;

  always_comb begin
    state_nx  = state;
    main_d_nx = main_d;
    skid_d_nx = skid_d;
    if (flush) begin
      state_nx  = PS_EMPTY;
      main_d_nx = '0;
      skid_d_nx = '0;
    end else begin
      unique case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            main_d_nx = in_data;
            state_nx  = PS_BUSY;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_d_nx = in_data;
          end else if (in_fire) begin
            skid_d_nx = in_data;
            state_nx  = PS_FULL;
          end else if (out_fire) begin
            state_nx = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only the drain path can move data
          if (out_fire) begin
            main_d_nx = skid_d;
            state_nx  = PS_BUSY;
          end
        end
        default: state_nx = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PS_EMPTY;
      main_d   <= '0;
      skid_d   <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      main_d   <= main_d_nx;
      skid_d   <= skid_d_nx;
      in_ready <= (state_nx != PS_FULL);
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic skid_v;
  assign skid_v = (state == PS_FULL);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (flush & (main_v | skid_v)),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and soak bench for pipe_stage_reg; counter expectations follow PIPE_STAGE_STATS_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data, a_stall_cnt, a_flush_cnt;

  logic        s_rst_n, s_in_valid, s_out_ready, s_flush;
  logic [0:0]  b_in_data, b_out_data;
  logic        b_in_ready, b_out_valid;
  logic [1:0]  b_stall_cnt, b_flush_cnt;
  logic [96:0] c_in_data, c_out_data;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_stall_cnt, c_flush_cnt;

  pipe_stage_reg #(.WIDTH(32), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_stage_reg #(.WIDTH(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(s_out_ready),
    .out_data(b_out_data), .flush(s_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  pipe_stage_reg #(.WIDTH(97), .CNT_W(32)) u_c (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(s_out_ready),
    .out_data(c_out_data), .flush(s_flush), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = '0;
    tick();
    a_rst_n = 1'b1;
  endtask

  task automatic fill_ab();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    tick();
    a_in_data = 32'hB;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h55; a_out_ready = 1'b0; a_flush = 1'b0;
    tick();
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 1", a_in_ready); end
    checks++; if (u_a.state !== PS_EMPTY) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", u_a.state, PS_EMPTY); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", a_stall_cnt); end
    checks++; if (a_flush_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_flush_cnt: got %0d want 0", a_flush_cnt); end
    a_rst_n = 1'b1; a_in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'(i); a_out_ready = 1'b1;
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) begin errors++; $display("[TB] FAIL stream_data[%0d]: got v=%0b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, i); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready[%0d]: got %0b want 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_skid_fill_drain();
    reset_a();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_out_data !== 32'hA) begin errors++; $display("[TB] FAIL skid_first: got rdy=%0b d=%h want rdy=1 d=a", a_in_ready, a_out_data); end
    a_in_data = 32'hB;
    tick();
    checks++; if (u_a.state !== PS_FULL) begin errors++; $display("[TB] FAIL skid_state_full: got %0d want %0d", u_a.state, PS_FULL); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_in_ready_low: got %0b want 0", a_in_ready); end
    checks++; if (a_out_data !== 32'hA) begin errors++; $display("[TB] FAIL skid_hold_a: got %h want a", a_out_data); end
    a_in_data = 32'hD;
    tick();
    checks++; if (u_a.state !== PS_FULL || a_out_data !== 32'hA) begin errors++; $display("[TB] FAIL skid_reject: got st=%0d d=%h want st=%0d d=a", u_a.state, a_out_data, PS_FULL); end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin errors++; $display("[TB] FAIL skid_drain_b: got v=%0b d=%h want v=1 d=b", a_out_valid, a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ready_back: got %0b want 1", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL skid_empty: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_flush_full();
    reset_a();
    fill_ab();
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hC; a_out_ready = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %0b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %0b want 1", a_in_ready); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("[TB] FAIL flush_out_data: got %h want 0", a_out_data); end
    checks++; if (a_flush_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL flush_cnt_full: got %0d want %0d", a_flush_cnt, STATS ? 1 : 0); end
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_c[%0d]: got v=%0b d=%h want v=0", i, a_out_valid, a_out_data); end
    end
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    checks++; if (a_flush_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL flush_cnt_empty: got %0d want %0d", a_flush_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_stall_count();
    reset_a();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h77;
    tick();
    a_in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (a_stall_cnt !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("[TB] FAIL stall_cnt_5: got %0d want %0d", a_stall_cnt, STATS ? 5 : 0); end
    checks++; if (a_out_data !== 32'h77) begin errors++; $display("[TB] FAIL stall_hold: got %h want 77", a_out_data); end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_stall_cnt !== (STATS ? 32'd5 : 32'd0) || a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_after: got cnt=%0d v=%0b want cnt=%0d v=0", a_stall_cnt, a_out_valid, STATS ? 5 : 0); end
  endtask

  task automatic test_saturation();
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0; b_in_data = '0; c_in_data = '0;
    tick();
    s_rst_n = 1'b1; s_in_valid = 1'b1; b_in_data = 1'b1; c_in_data = 97'h1_0000_0000_0000_0000_0000_0005;
    tick();
    s_in_valid = 1'b0;
    repeat (6) tick();
    checks++; if (b_stall_cnt !== (STATS ? 2'd3 : 2'd0)) begin errors++; $display("[TB] FAIL sat_cnt_w2: got %0d want %0d", b_stall_cnt, STATS ? 3 : 0); end
    checks++; if (c_stall_cnt !== (STATS ? 32'd6 : 32'd0)) begin errors++; $display("[TB] FAIL stall_cnt_6: got %0d want %0d", c_stall_cnt, STATS ? 6 : 0); end
    checks++; if (c_out_data !== 97'h1_0000_0000_0000_0000_0000_0005) begin errors++; $display("[TB] FAIL wide_data: got %h want 1000000000000000000000005", c_out_data); end
    s_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    reset_a();
    fill_ab();
    a_rst_n = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hE; a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_outputs: got v=%0b d=%h rdy=%0b want v=0 d=0 rdy=1", a_out_valid, a_out_data, a_in_ready); end
    checks++; if (u_a.state !== PS_EMPTY || a_stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midreset_state: got st=%0d cnt=%0d want st=0 cnt=0", u_a.state, a_stall_cnt); end
    a_rst_n = 1'b1; a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_emit[%0d]: got v=%0b d=%h want v=0", i, a_out_valid, a_out_data); end
    end
  endtask

  task automatic test_random_soak();
    logic [0:0]  qb[$];
    logic [96:0] qc[$];
    logic        b_in_f, b_out_f, c_in_f, c_out_f;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0;
    tick();
    s_rst_n = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_in_valid  = ($urandom_range(0, 9) < 7);
      s_out_ready = ($urandom_range(0, 9) < 6);
      s_flush     = ($urandom_range(0, 49) == 0);
      b_in_data   = 1'($urandom);
      c_in_data   = 97'({$urandom, $urandom, $urandom, $urandom});
      b_in_f  = s_in_valid & b_in_ready;
      b_out_f = b_out_valid & s_out_ready;
      c_in_f  = s_in_valid & c_in_ready;
      c_out_f = c_out_valid & s_out_ready;
      checks++; if (b_in_ready !== (qb.size() < 2)) begin errors++; $display("[TB] FAIL soak_w1_ready@%0d: got %0b want %0b", cyc, b_in_ready, qb.size() < 2); end
      checks++; if (b_out_valid !== (qb.size() != 0)) begin errors++; $display("[TB] FAIL soak_w1_valid@%0d: got %0b want %0b", cyc, b_out_valid, qb.size() != 0); end
      if (b_out_valid && qb.size() != 0) begin
        checks++; if (b_out_data !== qb[0]) begin errors++; $display("[TB] FAIL soak_w1_data@%0d: got %h want %h", cyc, b_out_data, qb[0]); end
      end
      checks++; if (c_in_ready !== (qc.size() < 2)) begin errors++; $display("[TB] FAIL soak_w97_ready@%0d: got %0b want %0b", cyc, c_in_ready, qc.size() < 2); end
      checks++; if (c_out_valid !== (qc.size() != 0)) begin errors++; $display("[TB] FAIL soak_w97_valid@%0d: got %0b want %0b", cyc, c_out_valid, qc.size() != 0); end
      if (c_out_valid && qc.size() != 0) begin
        checks++; if (c_out_data !== qc[0]) begin errors++; $display("[TB] FAIL soak_w97_data@%0d: got %h want %h", cyc, c_out_data, qc[0]); end
      end
      // A flush still lets the current downstream transfer complete.
      if (b_out_f && qb.size() != 0) void'(qb.pop_front());
      if (c_out_f && qc.size() != 0) void'(qc.pop_front());
      if (s_flush) begin
        qb.delete();
        qc.delete();
      end else begin
        if (b_in_f) qb.push_back(b_in_data);
        if (c_in_f) qc.push_back(c_in_data);
      end
      tick();
    end
    s_in_valid = 1'b0; s_flush = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = '0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0;
    b_in_data = '0; c_in_data = '0;
    test_reset();
    test_streaming();
    test_skid_fill_drain();
    test_flush_full();
    test_stall_count();
    test_reset_mid();
    test_saturation();
    test_random_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
